pe_col_drain: RTL

Output drain for one systolic-array column. Takes the bottom PE's `o_o` stream (ACC_BW accumulator, 2·FRA_BW fractional bits) and rounds and saturates it to the MUL_BW fixed-point operand format: INT_BW integer bits, FRA_BW fractional bits, sign-extended. Buffers results in a small FIFO toward a valid/ready consumer (writeback or next-layer feeder). Tags the last result of each column frame.

---
 rtl/pe_col_drain.sv | 130 +++++++++++++
 1 files changed

// File: rtl/pe_col_drain.sv
// Output drain for one systolic-array column: rounds/saturates accumulator results
// into the operand format and buffers them toward a valid/ready consumer with frame tagging.
module pe_col_drain #(
    parameter int INT_BW = 5,
    parameter int FRA_BW = 5,
    parameter int MUL_BW = 16,
    parameter int ACC_BW = 32,
    parameter int DEPTH  = 4,
    parameter int ROWS   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic [ACC_BW-1:0]          o_i,
    input  logic                       o_vld_i,
    output logic [MUL_BW-1:0]          d_o,
    output logic                       d_vld_o,
    input  logic                       d_rdy_i,
    output logic                       last_o,
    output logic [$clog2(DEPTH+1)-1:0] cnt_o,
    output logic                       ovf_o,
    output logic                       sat_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int OW = INT_BW + FRA_BW + 1;
    localparam int XW = ACC_BW + 1;

    localparam logic signed [XW-1:0] HALF = XW'(64'sd1 <<< (FRA_BW - 1));
    localparam logic signed [XW-1:0] MAXV = XW'((64'sd1 <<< (OW - 1)) - 64'sd1);
    localparam logic signed [XW-1:0] MINV = -MAXV - XW'(1);
    localparam logic [OW-1:0]        MAXO = MAXV[OW-1:0];
    localparam logic [OW-1:0]        MINO = MINV[OW-1:0];

    // One extra headroom bit keeps the rounding add from overflowing.
    logic signed [XW-1:0] ext_val;
    logic signed [XW-1:0] rnd_val;
    logic signed [XW-1:0] shf_val;
    logic                 clip_hi;
    logic                 clip_lo;
    logic signed [OW-1:0] clamp_val;
    logic [MUL_BW-1:0]    conv_val;

    assign ext_val   = {o_i[ACC_BW-1], o_i};
    assign rnd_val   = ext_val + HALF;
    assign shf_val   = rnd_val >>> FRA_BW;
    assign clip_hi   = shf_val > MAXV;
    assign clip_lo   = shf_val < MINV;
    assign clamp_val = clip_hi ? MAXO : (clip_lo ? MINO : shf_val[OW-1:0]);
    assign conv_val  = MUL_BW'(clamp_val);

    logic [MUL_BW-1:0] s1_d_reg;
    logic              s1_vld_reg;
    logic [MUL_BW-1:0] mem_reg [DEPTH];
    logic [PW-1:0]     wr_ptr_reg;
    logic [PW-1:0]     rd_ptr_reg;
    logic [CW-1:0]     cnt_reg;
    logic [RW-1:0]     pop_cnt_reg;
    logic              ovf_reg;
    logic              sat_reg;

    logic clr;
    logic full;
    logic pop;
    logic push;
    logic drop;

    assign clr  = rst | flush_i;
    assign full = (cnt_reg == CW'(DEPTH));
    assign pop  = d_vld_o & d_rdy_i;
    assign push = s1_vld_reg & (~full | pop);
    assign drop = s1_vld_reg & full & ~pop;

    always_ff @(posedge clk) begin
        if (clr) begin
            s1_d_reg   <= '0;
            s1_vld_reg <= 1'b0;
            sat_reg    <= 1'b0;
        end else begin
            s1_d_reg   <= conv_val;
            s1_vld_reg <= o_vld_i;
            if (o_vld_i && (clip_hi || clip_lo))
                sat_reg <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++)
                mem_reg[i] <= '0;
        end else if (push) begin
            mem_reg[wr_ptr_reg] <= s1_d_reg;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            cnt_reg     <= '0;
            pop_cnt_reg <= '0;
            ovf_reg     <= 1'b0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (pop) begin
                rd_ptr_reg  <= rd_ptr_reg + PW'(1);
                pop_cnt_reg <= (pop_cnt_reg == RW'(ROWS - 1)) ? '0 : pop_cnt_reg + RW'(1);
            end
            case ({push, pop})
                2'b10:   cnt_reg <= cnt_reg + CW'(1);
                2'b01:   cnt_reg <= cnt_reg - CW'(1);
                default: cnt_reg <= cnt_reg;
            endcase
            if (drop)
                ovf_reg <= 1'b1;
        end
    end

    assign d_o     = mem_reg[rd_ptr_reg];
    assign d_vld_o = (cnt_reg != '0);
    assign last_o  = d_vld_o && (pop_cnt_reg == RW'(ROWS - 1));
    assign cnt_o   = cnt_reg;
    assign ovf_o   = ovf_reg;
    assign sat_o   = sat_reg;

endmodule
